// File: rtl/idli_sqi_mem_m.sv
// SQI SRAM responder: decodes READ/WRITE transactions from a quad-SPI initiator into a byte array.
// SCK is oversampled on the system clock; all protocol activity is keyed off detected edges.
module idli_sqi_mem_m #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DUMMY_NIB = 2
) (
  input  logic       i_mem_gck,
  input  logic       i_mem_rst_n,
  input  logic       i_mem_sck,
  input  logic       i_mem_cs,
  input  logic [3:0] i_mem_sio,
  output logic [3:0] o_mem_sio,
  output logic       o_mem_sio_oe
);

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StDummy,
    StRdata,
    StWdata,
    StIgnore
  } state_e;

  state_e              state_q;
  logic                sck_q;
  logic [2:0]          cnt_q;
  logic [7:0]          cmd_q;
  logic [11:0]         addr_sh_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          wr_nib_q;
  logic [7:0]          rd_byte_q;
  logic [3:0]          sio_q;
  logic                oe_q;

  logic [7:0]          mem [2**ADDR_W];

  logic                rise;
  logic                fall;
  logic [ADDR_W-1:0]   addr_next;
  logic [7:0]          rd_now;
  logic [7:0]          rd_nxt;
  logic                mem_we;
  logic [7:0]          mem_wdata;

  always_comb begin
    rise      = i_mem_sck & ~sck_q & ~i_mem_cs;
    fall      = ~i_mem_sck & sck_q & ~i_mem_cs;
    addr_next = addr_q + ADDR_W'(1);
    rd_now    = mem[addr_q];
    rd_nxt    = mem[addr_next];
    // Second nibble of a byte completes it; the write lands on that same detected rise.
    mem_we    = (state_q == StWdata) && rise && cnt_q[0];
    mem_wdata = {wr_nib_q, i_mem_sio};
  end

  always_ff @(posedge i_mem_gck) begin
    if (mem_we) begin
      mem[addr_q] <= mem_wdata;
    end
  end

  always_ff @(posedge i_mem_gck or negedge i_mem_rst_n) begin
    if (!i_mem_rst_n) begin
      state_q   <= StIdle;
      sck_q     <= 1'b0;
      cnt_q     <= 3'd0;
      cmd_q     <= 8'h00;
      addr_sh_q <= 12'h000;
      addr_q    <= '0;
      wr_nib_q  <= 4'h0;
      rd_byte_q <= 8'h00;
      sio_q     <= 4'h0;
      oe_q      <= 1'b0;
    end else begin
      sck_q <= i_mem_sck;
      if (i_mem_cs) begin
        state_q <= StIdle;
        cnt_q   <= 3'd0;
        sio_q   <= 4'h0;
        oe_q    <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q <= StCmd;
            cnt_q   <= 3'd0;
          end
          StCmd: begin
            if (rise) begin
              cmd_q <= {cmd_q[3:0], i_mem_sio};
              if (cnt_q == 3'd1) begin
                state_q <= StAddr;
                cnt_q   <= 3'd0;
              end else begin
                cnt_q <= cnt_q + 3'd1;
              end
            end
          end
          StAddr: begin
            if (rise) begin
              addr_sh_q <= {addr_sh_q[7:0], i_mem_sio};
              if (cnt_q == 3'd3) begin
                // Upper address bits beyond the array size are dropped.
                addr_q <= ADDR_W'({addr_sh_q, i_mem_sio});
                cnt_q  <= 3'd0;
                if (cmd_q == 8'h03) begin
                  state_q <= StDummy;
                end else if (cmd_q == 8'h02) begin
                  state_q <= StWdata;
                end else begin
                  state_q <= StIgnore;
                end
              end else begin
                cnt_q <= cnt_q + 3'd1;
              end
            end
          end
          StDummy: begin
            if (rise) begin
              if (cnt_q == 3'(DUMMY_NIB - 1)) begin
                state_q   <= StRdata;
                cnt_q     <= 3'd0;
                rd_byte_q <= rd_now;
                sio_q     <= rd_now[7:4];
                oe_q      <= 1'b1;
              end else begin
                cnt_q <= cnt_q + 3'd1;
              end
            end
          end
          StRdata: begin
            // cnt_q[0] selects the nibble to present after the next fall: 0 = high, 1 = low.
            if (rise) begin
              cnt_q <= {2'b00, ~cnt_q[0]};
              if (cnt_q[0]) begin
                addr_q    <= addr_next;
                rd_byte_q <= rd_nxt;
              end
            end else if (fall) begin
              sio_q <= cnt_q[0] ? rd_byte_q[3:0] : rd_byte_q[7:4];
            end
          end
          StWdata: begin
            if (rise) begin
              if (!cnt_q[0]) begin
                wr_nib_q <= i_mem_sio;
                cnt_q    <= 3'd1;
              end else begin
                cnt_q  <= 3'd0;
                addr_q <= addr_next;
              end
            end
          end
          StIgnore: begin
            state_q <= StIgnore;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign o_mem_sio    = sio_q;
  assign o_mem_sio_oe = oe_q;

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Scoreboard bench for idli_sqi_mem_m: bench acts as SQI initiator, a byte-array model predicts
// read nibbles, and a monitor compares them at every SCK rise while the responder drives SIO.
module tb_idli_sqi_mem_m;

  localparam int unsigned DummyNib = 2;

  logic       gck = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0;
  logic       cs = 1'b1;
  logic [3:0] sio_i = 4'h0;
  logic [3:0] sio_o;
  logic       oe;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  logic [3:0] exp_nib;
  logic [7:0] ref_mem[256];
  logic [7:0] wbuf[8];

  idli_sqi_mem_m #(
    .ADDR_W   (8),
    .DUMMY_NIB(DummyNib)
  ) dut (
    .i_mem_gck   (gck),
    .i_mem_rst_n (rst_n),
    .i_mem_sck   (sck),
    .i_mem_cs    (cs),
    .i_mem_sio   (sio_i),
    .o_mem_sio   (sio_o),
    .o_mem_sio_oe(oe)
  );

  always #5 gck = ~gck;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every initiator sample point with the responder driving consumes one expectation.
  always @(posedge sck) begin
    if (oe === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_oe", 32'(oe), 32'd0);
      end else begin
        exp_nib = exp_q.pop_front();
        chk("read_nibble", 32'(sio_o), 32'(exp_nib));
      end
    end
  end

  task automatic nib(input logic [3:0] v);
    sio_i = v;
    #30;
    sck = 1'b1;
    #30;
    sck = 1'b0;
  endtask

  task automatic hdr(input logic [7:0] c, input logic [15:0] a);
    cs = 1'b0;
    nib(c[7:4]);
    nib(c[3:0]);
    nib(a[15:12]);
    nib(a[11:8]);
    nib(a[7:4]);
    nib(a[3:0]);
  endtask

  task automatic write_txn(input logic [15:0] a, input int n);
    logic [7:0] idx;
    hdr(8'h02, a);
    for (int i = 0; i < n; i++) begin
      nib(wbuf[i][7:4]);
      nib(wbuf[i][3:0]);
      idx = a[7:0] + 8'(i);
      ref_mem[idx] = wbuf[i];
    end
    chk("write_oe", 32'(oe), 32'd0);
    cs = 1'b1;
    #40;
  endtask

  task automatic read_txn(input logic [15:0] a, input int n);
    logic [7:0] idx;
    hdr(8'h03, a);
    for (int d = 0; d < DummyNib; d++) nib(4'($urandom));
    for (int i = 0; i < n; i++) begin
      idx = a[7:0] + 8'(i);
      exp_q.push_back(ref_mem[idx][7:4]);
      nib(4'($urandom));
      exp_q.push_back(ref_mem[idx][3:0]);
      nib(4'($urandom));
    end
    cs = 1'b1;
    #5;
    chk("oe_until_cs_sampled", 32'(oe), 32'd1);
    #5;
    chk("oe_after_cs_high", 32'(oe), 32'd0);
    #30;
  endtask

  initial begin
    #1;
    chk("reset_oe", 32'(oe), 32'd0);
    chk("reset_sio", 32'(sio_o), 32'd0);
    #20;
    rst_n = 1'b1;
    @(posedge gck);
    #2;

    // Basic write then read-back.
    wbuf[0] = 8'hAB;
    wbuf[1] = 8'hCD;
    write_txn(16'h0010, 2);
    read_txn(16'h0010, 2);

    // Address wrap at the top of the array.
    wbuf[0] = 8'h12;
    wbuf[1] = 8'h34;
    write_txn(16'h00FF, 2);
    read_txn(16'h00FF, 2);

    // Abort mid-byte: only the completed byte lands.
    wbuf[0] = 8'h99;
    write_txn(16'h0021, 1);
    cs = 1'b0;
    nib(4'h0); nib(4'h2); nib(4'h0); nib(4'h0); nib(4'h2); nib(4'h0);
    nib(4'h5); nib(4'h6); nib(4'h7);
    cs = 1'b1;
    #40;
    ref_mem[8'h20] = 8'h56;
    read_txn(16'h0020, 2);

    // Illegal command: nothing written, responder never drives.
    wbuf[0] = 8'h5A;
    wbuf[1] = 8'hC3;
    write_txn(16'h0030, 2);
    cs = 1'b0;
    nib(4'hF); nib(4'hF); nib(4'h0); nib(4'h0); nib(4'h3); nib(4'h0);
    nib(4'h1); nib(4'h2); nib(4'h3); nib(4'h4);
    chk("ignore_oe", 32'(oe), 32'd0);
    cs = 1'b1;
    #40;
    read_txn(16'h0030, 2);

    // Randomized write/read-back, upper address bits randomized too.
    for (int t = 0; t < 16; t++) begin
      int          n;
      logic [15:0] a;
      n = $urandom_range(1, 6);
      a = 16'($urandom);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      write_txn(a, n);
      read_txn(a, n);
    end

    // Asynchronous reset while the responder is driving read data.
    hdr(8'h03, 16'h0010);
    for (int d = 0; d < DummyNib; d++) nib(4'h0);
    exp_q.push_back(ref_mem[8'h10][7:4]);
    nib(4'h0);
    #15;
    chk("oe_before_reset", 32'(oe), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_oe", 32'(oe), 32'd0);
    chk("async_reset_sio", 32'(sio_o), 32'd0);
    cs = 1'b1;
    #20;
    rst_n = 1'b1;
    @(posedge gck);
    #2;
    #30;
    read_txn(16'h0010, 1);

    #50;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
